sopc_2_step_generator: RTL and testbench

Avalon-MM slave that turns the general timer's one-cycle `timeout_pulse` into a step/direction pulse train for a stepper driver. Software programs a step count, a period in ticks and a direction, then starts the block. It emits exactly that many step pulses, tracks an absolute position, and raises `irq` on completion. It sits directly downstream of the timer; its `tick_in` connects to the timer's `timeout_pulse`.

---
 rtl/sopc_2_step_generator_pkg.sv | 38 +++
 rtl/sopc_2_step_generator_if.sv | 32 +++
 rtl/sopc_2_step_generator_phase_cnt.sv | 37 +++
 rtl/sopc_2_step_generator.sv | 231 +++++++++++++++++++++++
 tb/tb_sopc_2_step_generator.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sopc_2_step_generator_pkg.sv
// ---------------------------------------------------------------------------
// sopc_2_stepgen_pkg
// Shared definitions for the step/direction pulse generator:
//   - register map addresses (0..5)
//   - CONTROL register bit positions
//   - sequencer state encoding (IDLE / HIGH / LOW)
//   - phase-length helpers derived from the ticks-per-step value
// ---------------------------------------------------------------------------
package sopc_2_stepgen_pkg;

  localparam logic [2:0] ADDR_STATUS     = 3'd0;
  localparam logic [2:0] ADDR_CONTROL    = 3'd1;
  localparam logic [2:0] ADDR_STEP_COUNT = 3'd2;
  localparam logic [2:0] ADDR_TPS        = 3'd3;
  localparam logic [2:0] ADDR_REMAINING  = 3'd4;
  localparam logic [2:0] ADDR_POSITION   = 3'd5;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_START  = 2;
  localparam int CTRL_STOP   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // High phase gets the smaller half so an odd TPS puts the extra tick low.
  function automatic logic [15:0] hi_len(input logic [15:0] tps);
    return tps >> 1;
  endfunction

  function automatic logic [15:0] lo_len(input logic [15:0] tps);
    return tps - (tps >> 1);
  endfunction

endpackage

// File: rtl/sopc_2_step_generator_if.sv
// ---------------------------------------------------------------------------
// sopc_2_step_generator_if
// Avalon-MM slave bus bundle for the step generator.
//   address    [2:0]  register select
//   chipselect        access qualifier
//   write_n           active-low write strobe
//   writedata  [15:0] write data
//   readdata   [15:0] registered read data (from slave)
// ---------------------------------------------------------------------------
interface sopc_2_step_generator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sopc_2_step_generator_phase_cnt.sv
// ---------------------------------------------------------------------------
// sopc_2_step_phase_cnt
// Tick-gated phase down-counter.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : counting allowed (sequencer busy)
//   tick       : one-cycle timebase tick
//   load/value : load a new phase length (has priority over counting)
//   tcnt       : current count
//   expire     : tcnt==1 coincides with an enabled tick (phase ends)
// ---------------------------------------------------------------------------
module sopc_2_step_phase_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] value,
  output logic [15:0] tcnt,
  output logic        expire
);

  logic [15:0] tcnt_reg;

  assign tcnt   = tcnt_reg;
  assign expire = enable & tick & (tcnt_reg == 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_reg <= 16'd0;
    end else if (load) begin
      tcnt_reg <= value;
    end else if (enable && tick) begin
      tcnt_reg <= tcnt_reg - 16'd1;
    end
  end

endmodule

// File: rtl/sopc_2_step_generator.sv
// ---------------------------------------------------------------------------
// sopc_2_step_generator
// Avalon-MM slave turning the timer's one-cycle tick into a step/direction
// pulse train: emits STEP_COUNT pulses of TPS ticks each, tracks a signed
// 16-bit position and raises irq on completion.
//   clk, reset : clock, asynchronous active-high reset
//   tick_in    : timebase tick from the timer's timeout_pulse
//   bus        : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq        : done & irq_en
//   step_out   : step pulse, high during the HIGH phase
//   dir_out    : direction latched at start
//   busy       : move in progress
// ---------------------------------------------------------------------------
module sopc_2_step_generator
  import sopc_2_stepgen_pkg::*;
#(
  parameter logic [15:0] TPS_RESET = 16'd2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick_in,
  sopc_2_step_generator_if.slave          bus,
  output logic                            irq,
  output logic                            step_out,
  output logic                            dir_out,
  output logic                            busy
);

  state_t      state_reg, state_next;

  logic        done_reg;
  logic        irq_en_reg;
  logic        dir_reg;
  logic        dir_out_reg;
  logic [15:0] step_count_reg;
  logic [15:0] tps_reg;
  logic [15:0] remaining_reg;
  logic [15:0] position_reg;
  logic [15:0] lo_reg;
  logic [15:0] readdata_reg;

  // Bus decode
  logic wr_en, wr_status, wr_control, wr_step_count, wr_tps, wr_position;
  logic start_req, stop_req;

  assign wr_en         = bus.chipselect & ~bus.write_n;
  assign wr_status     = wr_en & (bus.address == ADDR_STATUS);
  assign wr_control    = wr_en & (bus.address == ADDR_CONTROL);
  assign wr_step_count = wr_en & (bus.address == ADDR_STEP_COUNT);
  assign wr_tps        = wr_en & (bus.address == ADDR_TPS);
  assign wr_position   = wr_en & (bus.address == ADDR_POSITION);

  // A write carrying both start and stop is treated as a stop only.
  assign stop_req  = wr_control & bus.writedata[CTRL_STOP];
  assign start_req = wr_control & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_STOP];

  // Phase counter
  logic        cnt_load;
  logic [15:0] cnt_value;
  logic [15:0] tcnt;
  logic        expire;

  sopc_2_step_phase_cnt u_phase_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .tick   (tick_in),
    .load   (cnt_load),
    .value  (cnt_value),
    .tcnt   (tcnt),
    .expire (expire)
  );

  // Sequencer decisions
  logic start_move;   // accepted start with a valid program
  logic empty_start;  // start with nothing to do: completes immediately
  logic enter_high;   // (re)entering HIGH, sample phase lengths
  logic step_taken;   // HIGH phase finished: count the step
  logic move_done;    // final LOW phase finished

  always_comb begin
    state_next  = state_reg;
    start_move  = 1'b0;
    empty_start = 1'b0;
    enter_high  = 1'b0;
    step_taken  = 1'b0;
    move_done   = 1'b0;
    cnt_load    = 1'b0;
    cnt_value   = 16'd0;

    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          if ((step_count_reg == 16'd0) || (tps_reg < 16'd2)) begin
            empty_start = 1'b1;
          end else begin
            start_move = 1'b1;
            enter_high = 1'b1;
            state_next = ST_HIGH;
          end
        end
      end
      ST_HIGH: begin
        if (stop_req) begin
          state_next = ST_IDLE;
        end else if (expire) begin
          step_taken = 1'b1;
          cnt_load   = 1'b1;
          cnt_value  = lo_reg;
          state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (stop_req) begin
          state_next = ST_IDLE;
        end else if (expire) begin
          if (remaining_reg == 16'd0) begin
            move_done  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            enter_high = 1'b1;
            state_next = ST_HIGH;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (enter_high) begin
      cnt_load  = 1'b1;
      cnt_value = hi_len(tps_reg);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath and register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_reg       <= 1'b0;
      irq_en_reg     <= 1'b0;
      dir_reg        <= 1'b0;
      dir_out_reg    <= 1'b0;
      step_count_reg <= 16'd0;
      tps_reg        <= TPS_RESET;
      remaining_reg  <= 16'd0;
      position_reg   <= 16'd0;
      lo_reg         <= 16'd0;
    end else begin
      if (wr_control) begin
        irq_en_reg <= bus.writedata[CTRL_IRQ_EN];
        dir_reg    <= bus.writedata[CTRL_DIR];
      end
      if (wr_step_count) begin
        step_count_reg <= bus.writedata;
      end
      if (wr_tps) begin
        tps_reg <= bus.writedata;
      end

      // Completion beats a simultaneous STATUS write.
      if (empty_start || move_done) begin
        done_reg <= 1'b1;
      end else if (wr_status) begin
        done_reg <= 1'b0;
      end

      // Direction comes straight from the start write, not the stored copy.
      if (start_move) begin
        dir_out_reg <= bus.writedata[CTRL_DIR];
      end

      if (start_move) begin
        remaining_reg <= step_count_reg;
      end else if (step_taken) begin
        remaining_reg <= remaining_reg - 16'd1;
      end

      if (enter_high) begin
        lo_reg <= lo_len(tps_reg);
      end

      // Software load beats a simultaneous step update.
      if (wr_position) begin
        position_reg <= bus.writedata;
      end else if (step_taken) begin
        position_reg <= dir_out_reg ? (position_reg + 16'd1) : (position_reg - 16'd1);
      end
    end
  end

  // Registered read path
  logic [15:0] read_mux;

  always_comb begin
    read_mux = 16'd0;
    case (bus.address)
      ADDR_STATUS:     read_mux = {14'd0, busy, done_reg};
      ADDR_CONTROL:    read_mux = {14'd0, dir_reg, irq_en_reg};
      ADDR_STEP_COUNT: read_mux = step_count_reg;
      ADDR_TPS:        read_mux = tps_reg;
      ADDR_REMAINING:  read_mux = remaining_reg;
      ADDR_POSITION:   read_mux = position_reg;
      default:         read_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_reg <= 16'd0;
    end else begin
      readdata_reg <= read_mux;
    end
  end

  // step_out is decoded from the state register so reset drops it at once.
  assign step_out     = (state_reg == ST_HIGH);
  assign busy         = (state_reg != ST_IDLE);
  assign dir_out      = dir_out_reg;
  assign irq          = done_reg & irq_en_reg;
  assign bus.readdata = readdata_reg;

endmodule

// File: tb/tb_sopc_2_step_generator.sv
module tb_sopc_2_step_generator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_in = 1'b0;
  logic irq, step_out, dir_out, busy;

  sopc_2_step_generator_if bus_if ();

  sopc_2_step_generator #(.TPS_RESET(16'd2)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .bus      (bus_if),
    .irq      (irq),
    .step_out (step_out),
    .dir_out  (dir_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Activity monitor: rising edges of step_out and busy cycles.
  int   pulses = 0;
  int   busy_cycles = 0;
  logic prev_step = 1'b0;
  always @(posedge clk) begin
    if (step_out && !prev_step) pulses <= pulses + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
    prev_step <= step_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    cyc();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    $display("[TB] write addr=%0d data=0x%04h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    cyc();
    d = bus_if.readdata;
    bus_if.chipselect = 1'b0;
    $display("[TB] read  addr=%0d data=0x%04h", a, d);
  endtask

  // One timebase tick every 5 clocks.
  task automatic tick();
    repeat (4) cyc();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    logic [11:0] samp12;
    logic [5:0]  samp6;
    int p0, b0;

    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 16'd0;

    repeat (3) cyc();
    #2 reset = 1'b0;
    cyc();

    // Reset state
    check("rst_step_out", step_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_dir_out", dir_out, 1'b0);
    check("rst_readdata", bus_if.readdata, 16'd0);
    bus_read(3'd3, rd);
    check("rst_tps", rd, 16'd2);

    // Test 1: TPS=4, COUNT=3, dir=1, irq_en=1
    bus_write(3'd3, 16'd4);
    bus_write(3'd2, 16'd3);
    p0 = pulses;
    bus_write(3'd1, 16'h0007);
    check("t1_start_step", step_out, 1'b1);
    check("t1_start_busy", busy, 1'b1);
    check("t1_start_dir", dir_out, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      samp12[i] = step_out;
    end
    check("t1_wave", samp12, 12'b000110011001);
    check("t1_busy_end", busy, 1'b0);
    check("t1_irq", irq, 1'b1);
    check("t1_pulses", pulses - p0, 3);
    bus_read(3'd5, rd);
    check("t1_position", rd, 16'd3);
    bus_read(3'd4, rd);
    check("t1_remaining", rd, 16'd0);
    bus_read(3'd0, rd);
    check("t1_status", rd, 16'd1);
    bus_write(3'd0, 16'd0);
    check("t1_irq_clear", irq, 1'b0);

    // Test 2: POSITION=0, dir=0, COUNT=2, TPS=3
    bus_write(3'd5, 16'd0);
    bus_write(3'd2, 16'd2);
    bus_write(3'd3, 16'd3);
    p0 = pulses;
    bus_write(3'd1, 16'h0005);
    check("t2_start_step", step_out, 1'b1);
    check("t2_dir_out", dir_out, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      samp6[i] = step_out;
    end
    check("t2_wave", samp6, 6'b000100);
    check("t2_pulses", pulses - p0, 2);
    bus_read(3'd5, rd);
    check("t2_position", rd, 16'hFFFE);
    bus_read(3'd0, rd);
    check("t2_status", rd, 16'd1);
    bus_write(3'd0, 16'd0);

    // Test 3: COUNT=0 start completes immediately
    bus_write(3'd2, 16'd0);
    p0 = pulses;
    b0 = busy_cycles;
    bus_write(3'd1, 16'h0005);
    check("t3_busy", busy, 1'b0);
    check("t3_step", step_out, 1'b0);
    check("t3_irq", irq, 1'b1);
    bus_read(3'd0, rd);
    check("t3_status", rd, 16'd1);
    tick();
    tick();
    check("t3_pulses", pulses - p0, 0);
    check("t3_busy_cycles", busy_cycles - b0, 0);
    bus_read(3'd5, rd);
    check("t3_idle_tick_pos", rd, 16'hFFFE);

    // Test 4: COUNT=10, TPS=2, stop after 4th pulse falls
    bus_write(3'd0, 16'd0);
    bus_write(3'd5, 16'd0);
    bus_write(3'd2, 16'd10);
    bus_write(3'd3, 16'd2);
    p0 = pulses;
    bus_write(3'd1, 16'h0006);
    for (int i = 0; i < 7; i++) tick();
    check("t4_pre_stop_busy", busy, 1'b1);
    check("t4_pre_stop_step", step_out, 1'b0);
    bus_write(3'd1, 16'h0008);
    check("t4_stop_busy", busy, 1'b0);
    check("t4_stop_step", step_out, 1'b0);
    bus_read(3'd4, rd);
    check("t4_remaining", rd, 16'd6);
    bus_read(3'd5, rd);
    check("t4_position", rd, 16'd4);
    bus_read(3'd0, rd);
    check("t4_status", rd, 16'd0);
    check("t4_pulses", pulses - p0, 4);

    // Test 5: ignored restart, STATUS write on the final tick
    bus_write(3'd2, 16'd2);
    p0 = pulses;
    bus_write(3'd1, 16'h0007);
    tick();
    bus_write(3'd2, 16'd9);
    bus_write(3'd1, 16'h0007);
    bus_read(3'd4, rd);
    check("t5_remaining_restart", rd, 16'd1);
    tick();
    tick();
    repeat (4) cyc();
    tick_in = 1'b1;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = 3'd0;
    bus_if.writedata  = 16'd0;
    cyc();
    tick_in = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    check("t5_busy", busy, 1'b0);
    check("t5_irq", irq, 1'b1);
    bus_read(3'd0, rd);
    check("t5_status", rd, 16'd1);
    bus_read(3'd5, rd);
    check("t5_position", rd, 16'd6);
    check("t5_pulses", pulses - p0, 2);

    // Test 6: asynchronous reset mid-HIGH
    bus_write(3'd2, 16'd5);
    bus_write(3'd3, 16'd8);
    bus_write(3'd1, 16'h0007);
    bus_if.address = 3'd3;
    cyc();
    check("t6_pre_step", step_out, 1'b1);
    check("t6_pre_busy", busy, 1'b1);
    check("t6_pre_irq", irq, 1'b1);
    check("t6_pre_readdata", bus_if.readdata, 16'd8);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_step", step_out, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_irq", irq, 1'b0);
    check("t6_rst_readdata", bus_if.readdata, 16'd0);
    cyc();
    #3 reset = 1'b0;
    cyc();
    bus_read(3'd3, rd);
    check("t6_tps_reset", rd, 16'd2);
    bus_read(3'd2, rd);
    check("t6_count_reset", rd, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
